// File: rtl/mult_32_if.sv
// Handshake and operand bundle for the iterative 16x16 multiplier.
// The master drives the start request and operands; the slave returns the product and done.
interface mult_32_if;
  logic        init;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] pp;
  logic        done;

  modport master (output init, output A, output B, input pp, input done);
  modport slave  (input init, input A, input B, output pp, output done);
endinterface

// File: rtl/mult_32.sv
// Sequential 16x16 unsigned shift-and-add multiplier with an init/done handshake.
// One adder is reused for 16 iterations; done is registered and rises 17 edges after init is accepted.
module mult_32 (
  input  logic        clk,
  input  logic        rst,
  mult_32_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] a_sh_r;
  logic [31:0] pp_r;
  logic [15:0] b_sh_r;
  logic [4:0]  cnt_r;
  logic        done_r;

  // Control FSM, operand shift registers and the partial-product accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= 32'd0;
      b_sh_r  <= 16'd0;
      cnt_r   <= 5'd0;
      pp_r    <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      // done follows DONE one edge later, so it rises together with the 17th edge.
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (bus.init) begin
            a_sh_r  <= {16'd0, bus.A};
            b_sh_r  <= bus.B;
            pp_r    <= 32'd0;
            cnt_r   <= 5'd0;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (b_sh_r[0]) begin
            pp_r <= pp_r + a_sh_r;
          end else begin
            pp_r <= pp_r;
          end
          a_sh_r <= a_sh_r << 1;
          b_sh_r <= b_sh_r >> 1;
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == 5'd15) begin
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (!bus.init) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.pp   = pp_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mult_32.sv
// Directed bench for mult_32: a cycle-level behavioural model is checked every cycle,
// and each operation is also pinned against hand-computed products and latency.
module tb_mult_32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_32_if bus ();

  mult_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: phase 0 idle, 1 busy (counts 16 edges), 2 holding a finished product.
  int          m_phase    = 0;
  int          m_left     = 0;
  logic [31:0] m_prod     = 32'd0;
  logic [31:0] m_pp       = 32'd0;
  logic        m_done     = 1'b0;
  logic        m_pp_known = 1'b0;
  logic        m_valid    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase    = 0;
      m_done     = 1'b0;
      m_pp       = 32'd0;
      m_pp_known = 1'b1;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      m_done = (m_phase == 2);
      case (m_phase)
        0: if (bus.init) begin
             m_phase    = 1;
             m_left     = 16;
             m_prod     = {16'd0, bus.A} * {16'd0, bus.B};
             m_pp_known = 1'b0;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase    = 2;
               m_pp       = m_prod;
               m_pp_known = 1'b1;
             end
           end
        2: if (!bus.init) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
      if (m_pp_known) chk("model_pp", bus.pp, m_pp);
    end
  end

  // Start an operation; hold=0 keeps init high, chg swaps operands mid-calculation.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input logic [31:0] exp, input bit chg);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    bus.A = a;
    bus.B = b;
    bus.init = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == hold) bus.init = 1'b0;
      if (chg && n == 3) begin
        bus.A = 16'hFFFF;
        bus.B = 16'hFFFF;
      end
      if (bus.done) seen = 1'b1;
    end
    chk("latency", 32'(n), 32'd18);
    chk("product", bus.pp, exp);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.init = 1'b0;
    bus.A = 16'd0;
    bus.B = 16'd0;
    idle_cycles(3);
    chk("reset_pp", bus.pp, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    run_op(16'h00F7, 16'h007F, 2, 32'h00007A89, 1'b0);
    chk("model_f7x7f", m_prod, 32'd31369);
    idle_cycles(1);
    chk("done_low_after_release", {31'd0, bus.done}, 32'd0);
    chk("pp_held_in_idle", bus.pp, 32'h00007A89);
    idle_cycles(2);

    run_op(16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001, 1'b0);
    chk("model_ffff", m_prod, 32'hFFFE0001);
    idle_cycles(3);

    run_op(16'h1234, 16'h0000, 1, 32'h00000000, 1'b0);
    idle_cycles(3);
    run_op(16'h0000, 16'hBEEF, 1, 32'h00000000, 1'b0);
    idle_cycles(3);

    run_op(16'h0101, 16'h0202, 0, 32'h00020402, 1'b0);
    idle_cycles(5);
    chk("held_done_stays", {31'd0, bus.done}, 32'd1);
    bus.init = 1'b0;
    idle_cycles(3);
    chk("held_no_restart_done", {31'd0, bus.done}, 32'd0);
    chk("held_no_restart_pp", bus.pp, 32'h00020402);

    run_op(16'd3, 16'd5, 1, 32'h0000000F, 1'b1);
    chk("model_3x5", m_prod, 32'd15);
    idle_cycles(3);

    bus.A = 16'h1234;
    bus.B = 16'h5678;
    bus.init = 1'b1;
    idle_cycles(1);
    bus.init = 1'b0;
    idle_cycles(7);
    rst = 1'b1;
    idle_cycles(1);
    chk("midcalc_reset_pp", bus.pp, 32'd0);
    chk("midcalc_reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    run_op(16'd2, 16'd3, 1, 32'd6, 1'b0);
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
